// File: rtl/exp_pkg.sv
// rtl/exp_pkg.sv - shared constants and types for the exp range-reduction block
//
// Holds the ln2 constant, index range and datapath widths used by
// exp_range_red and int_sel. No ports.

package exp_pkg;

  // ln2 in Q0.16
  localparam int unsigned LN2_Q16 = 45426;
  // Largest index the selector can produce for an in-range argument
  localparam int unsigned I_MAX   = 20;
  // Q4.11 unsigned argument width
  localparam int unsigned DATA_W  = 15;
  // Q1.11 signed remainder width
  localparam int unsigned R_W     = 12;
  // Index width
  localparam int unsigned I_W     = 5;

  // Shift that aligns a Q4.11 argument with the Q0.16 ln2 constant
  localparam int unsigned FRAC_SHIFT = 5;

  // First out-of-range argument: 14.0 in Q4.11
  localparam logic [DATA_W-1:0] X_LIMIT = 15'h7000;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [I_W-1:0]    idx_t;
  typedef logic [R_W-1:0]    rem_t;

endpackage

// File: rtl/int_sel.sv
// rtl/int_sel.sv - combinational index selector, max(1, floor(x/ln2)) or 0 when x >= 14.0
//
// Ports:
//   data_i  in  DATA_W  unsigned Q4.11 argument x
//   idx_o   out I_W     1..I_MAX for in-range x, 0 when x is out of range

module int_sel
  import exp_pkg::*;
#(
  parameter int unsigned LN2 = exp_pkg::LN2_Q16
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [I_W-1:0]    idx_o
);

  // Argument rescaled to the Q.16 grid of the ln2 constant
  logic [DATA_W+FRAC_SHIFT-1:0] x_q16;
  assign x_q16 = {data_i, {FRAC_SHIFT{1'b0}}};

  // The index is the largest k with k*ln2 <= x, never below 1. Thresholds
  // are constants, so this unrolls into a bank of comparators.
  always_comb begin
    idx_o = idx_t'(1);
    for (int k = 2; k <= int'(I_MAX); k++) begin
      if (32'(x_q16) >= (k * LN2)) begin
        idx_o = idx_t'(k);
      end
    end
    if (data_i >= X_LIMIT) begin
      idx_o = '0;
    end
  end

endmodule

// File: rtl/exp_range_red.sv
// rtl/exp_range_red.sv - two-stage valid/ready range reduction x = i*ln2 + r for exp()
//
// Optional feature macro: EXP_RR_OVF_CNT_EN (adds the ovf_cnt port and counter).
//
// Ports:
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       input sample valid
//   in_ready   out  1       sample accepted this cycle when in_valid is high
//   in_data    in   15      unsigned Q4.11 argument x
//   out_valid  out  1       result valid
//   out_ready  in   1       downstream accepts the result
//   out_i      out  5       index max(1, floor(x/ln2)); 0 when out of range
//   out_r      out  12      signed Q1.11 remainder x - out_i*ln2
//   out_ovf    out  1       argument out of range (x >= 14.0)
//   ovf_cnt    out  16      saturating count of accepted out-of-range samples
//                           (only with EXP_RR_OVF_CNT_EN)

module exp_range_red
  import exp_pkg::*;
#(
  parameter int unsigned LN2_Q16 = exp_pkg::LN2_Q16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [I_W-1:0]    out_i,
  output logic [R_W-1:0]    out_r,
  output logic              out_ovf
`ifdef EXP_RR_OVF_CNT_EN
  ,
  output logic [15:0]       ovf_cnt
`endif
);

  localparam int unsigned DIFF_W = R_W + FRAC_SHIFT;

  // Stage 1 state
  logic  s1_valid_q, s1_valid_d;
  data_t s1_data_q,  s1_data_d;
  idx_t  s1_idx_q,   s1_idx_d;

  // Stage 2 (output) state
  logic  out_valid_q, out_valid_d;
  idx_t  out_i_q,     out_i_d;
  rem_t  out_r_q,     out_r_d;
  logic  out_ovf_q,   out_ovf_d;

  logic  s1_load;
  logic  s2_load;
  idx_t  sel_idx;

  logic [DIFF_W-1:0] x_sh;
  logic [DIFF_W-1:0] i_ln2;
  rem_t              rem;

  int_sel #(
    .LN2 (LN2_Q16)
  ) u_int_sel (
    .data_i (in_data),
    .idx_o  (sel_idx)
  );

  // Output stage frees up when empty or draining; stage 1 frees up when
  // empty or when its content moves on this cycle.
  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Remainder only needs its low R_W bits after the floor shift, so the
  // subtraction is carried out modulo 2^DIFF_W. Dropping the low
  // FRAC_SHIFT bits of the two's-complement difference is the floor shift.
  assign x_sh  = DIFF_W'({s1_data_q, {FRAC_SHIFT{1'b0}}});
  assign i_ln2 = DIFF_W'(32'(s1_idx_q) * LN2_Q16);
  assign rem   = R_W'((x_sh - i_ln2) >> FRAC_SHIFT);

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_idx_d    = s1_idx_q;
    out_valid_d = out_valid_q;
    out_i_d     = out_i_q;
    out_r_d     = out_r_q;
    out_ovf_d   = out_ovf_q;

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_idx_d  = sel_idx;
      end
    end

    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_i_d   = s1_idx_q;
        out_ovf_d = (s1_idx_q == '0);
        // Out-of-range results carry a zero remainder
        out_r_d   = (s1_idx_q == '0) ? '0 : rem;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_r_q     <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_idx_q    <= s1_idx_d;
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
      out_r_q     <= out_r_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_i     = out_i_q;
  assign out_r     = out_r_q;
  assign out_ovf   = out_ovf_q;

`ifdef EXP_RR_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Counted at acceptance, so samples later flushed by reset still count
  // until that reset clears the counter too.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (in_valid && s1_load && (sel_idx == '0) && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: doc/exp_range_red.md
EXP_RANGE_RED -- requirements
Module: exp_range_red

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: in_valid  in  1  input sample valid.
REQ-004 SHALL have ports: in_ready  out  1  block accepts a sample this cycle.
REQ-005 SHALL have ports: in_data  in  15  unsigned Q4.11 exponent argument x.
REQ-006 SHALL have ports: out_valid  out  1  result valid.
REQ-007 SHALL have ports: out_ready  in  1  downstream accepts a result.
REQ-008 SHALL have ports: out_i  out  5  integer index, max(1, floor(x/ln2)), 1..20; 0 when out of range.
REQ-009 SHALL have ports: out_r  out  12  signed Q1.11 remainder x - out_i*ln2.
REQ-010 SHALL have ports: out_ovf  out  1  argument out of range (x >= 14.0).
REQ-011 SHALL have parameter: LN2_Q16, default 45426, ln2 in Q0.16.
REQ-012 SHALL have, only with the macro of REQ-027, port ovf_cnt  out  16  count of accepted out-of-range samples.

Function
REQ-013 SHALL be a two-stage valid/ready pipeline; a transfer occurs on a cycle with valid and ready both high.
REQ-014 Stage 1 SHALL register in_data and the index produced combinationally from in_data by the index selector.
REQ-015 Stage 2 SHALL register out_i = stage-1 index, out_ovf = (index == 0), and out_r.
REQ-016 out_r SHALL be ((stage-1 data << 5) - index*LN2_Q16) arithmetically shifted right by 5 (floor), truncated to 12 bits, with no clamp.
REQ-017 When out_ovf = 1, out_r SHALL be 0 and out_i SHALL be 0.
REQ-018 Latency SHALL be 2 cycles from input transfer to out_valid with no stall; throughput SHALL be 1 sample/cycle.
REQ-019 Stage 2 SHALL load when !out_valid || out_ready; stage 1 SHALL load when !s1_valid || stage 2 loads.
REQ-020 in_ready SHALL equal the stage-1 load condition, with a combinational path from out_ready.
REQ-021 While out_valid && !out_ready, out_i, out_r and out_ovf SHALL hold stable.
REQ-022 Results SHALL leave in input order; no sample is lost or duplicated under any out_ready pattern.
REQ-023 Input and output transfers in the same cycle SHALL both complete with the pipeline full.

Reset
REQ-024 On rst_n low, all valid flags SHALL clear immediately: out_valid = 0, and in_ready = 1 while rst_n is low.
REQ-025 On rst_n low, out_i, out_r, out_ovf (and ovf_cnt) SHALL clear to 0.
REQ-026 Reset asserted mid-operation SHALL discard in-flight samples; the first accepted sample after release SHALL appear 2 cycles later.

Configuration
REQ-027 With EXP_RR_OVF_CNT_EN defined, ovf_cnt SHALL increment by 1 per accepted input whose index is 0, saturating at 0xFFFF.
REQ-028 Without EXP_RR_OVF_CNT_EN, the ovf_cnt port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 The shared package exp_pkg SHALL hold the following, and the block SHALL use the package copies only:
- LN2_Q16
- I_MAX = 20
- DATA_W = 15
- R_W = 12
- I_W = 5
REQ-030 The index selector SHALL be the existing int_sel module, instantiated once in stage 1; no other sub-module SHALL be used.

Verification
REQ-031 in_data=0x0000 -> out_i=1, out_r=-1420 (0xA74), out_ovf=0, out_valid 2 cycles after transfer.
REQ-032 in_data=0x1000 (2.0) -> out_i=2, out_r=1256; in_data=0x6FFF -> out_i=20, out_r=279.
REQ-033 in_data=0x7000 (14.0) -> out_i=0, out_r=0, out_ovf=1.
REQ-034 Three back-to-back inputs with out_ready=0 for 4 cycles:
- in_ready SHALL drop after the 2nd input;
- on release, outputs SHALL appear in order, with none lost.
REQ-035 rst_n pulsed low while out_valid=1 -> out_valid=0 during reset; next sample SHALL emerge 2 cycles after its transfer.
REQ-036 With EXP_RR_OVF_CNT_EN, 3 inputs of 0x7800 interleaved with 2 in-range inputs -> ovf_cnt=3.
